// File: rtl/framer_pkg.sv
// Shared states, sizing and entry layout for the AXI-Stream sample framer.
package framer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int OCC_WIDTH  = PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/framer_fifo.sv
// Synchronous FIFO with registered occupancy and no fall-through.
// Each word is pushed in one cycle and is visible at the head no earlier than the next.
module framer_fifo
  import framer_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH + 1,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/axis_sample_framer.sv
// Feeds the FIR AXI-Stream slave with exactly cfg_len beats, tlast on the final one.
// Define FRAMER_STALL_CNT_EN to add the stall_cnt back-pressure counter output.
module axis_sample_framer
  import framer_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_WIDTH,
  parameter int pLEN_WIDTH  = LEN_WIDTH,
  parameter int pFIFO_DEPTH = FIFO_DEPTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   cfg_start,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  input  logic [pDATA_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
`ifdef FRAMER_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic [pLEN_WIDTH-1:0]  sent_cnt
);

  state_t                  state;
  logic [pLEN_WIDTH-1:0]   len;
  logic [pLEN_WIDTH-1:0]   push_cnt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [pDATA_WIDTH:0]    fifo_head;
  logic                    start;
  logic                    push;
  logic                    pop;
  logic                    push_last;

  // in_ready deliberately ignores ss_tready so there is no combinational path through the FIFO.
  assign start     = (state == IDLE) && cfg_start;
  assign in_ready  = (state == RUN) && !fifo_full && (push_cnt < len);
  assign push      = in_valid && in_ready;
  assign pop       = ss_tvalid && ss_tready;
  assign push_last = (push_cnt == len - pLEN_WIDTH'(1));
  assign ss_tvalid = !fifo_empty;
  assign {ss_tlast, ss_tdata} = fifo_head;

  framer_fifo #(
    .WIDTH(pDATA_WIDTH + 1),
    .DEPTH(pFIFO_DEPTH)
  ) u_fifo (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .push     (push),
    .pop      (pop),
    .push_data({push_last, in_data}),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // busy/done are registered alongside the state so they mirror the state they describe.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      len      <= '0;
      push_cnt <= '0;
      sent_cnt <= '0;
    end else begin
      if (push) push_cnt <= push_cnt + pLEN_WIDTH'(1);
      if (pop && sent_cnt != len) sent_cnt <= sent_cnt + pLEN_WIDTH'(1);
      case (state)
        IDLE: begin
          if (start) begin
            len      <= cfg_len;
            push_cnt <= '0;
            sent_cnt <= '0;
            busy     <= 1'b1;
            if (cfg_len != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push && push_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && ss_tlast) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAMER_STALL_CNT_EN
  // Holds after done so software can read the back-pressure seen by the last frame.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      stall_cnt <= '0;
    end else if (start) begin
      stall_cnt <= '0;
    end else if (busy && ss_tvalid && !ss_tready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/axis_sample_framer.md
Name: axis_sample_framer

Overview:
- Upstream feeder for the FIR core's AXI-Stream slave input (ss_*).
- Accepts raw samples on a simple valid/ready port and buffers them in a small FIFO.
- Emits exactly the programmed number of beats to the FIR and asserts ss_tlast on the final beat.
- Signals a one-cycle done pulse when the last beat has been accepted downstream, so the FIR's data_length and tlast always agree.

Parameters:
- pDATA_WIDTH, 32, sample width.
- pLEN_WIDTH, 32, width of the frame-length register. Matches the FIR data_length register at 0x10.
- pFIFO_DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst  in  1  reset; synchronous, active-high.
- cfg_len  in  pLEN_WIDTH  frame length in samples; sampled on cfg_start.
- cfg_start  in  1  one-cycle start pulse.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the frame completes.
- in_valid  in  1  source sample valid.
- in_data  in  pDATA_WIDTH  source sample, signed.
- in_ready  out  1  framer can accept a sample.
- ss_tvalid  out  1  AXI-Stream valid to FIR.
- ss_tdata  out  pDATA_WIDTH  AXI-Stream data to FIR.
- ss_tlast  out  1  marks final beat of the frame.
- ss_tready  in  1  FIR ready.
- sent_cnt  out  pLEN_WIDTH  beats handshaken on ss_* in the current frame.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0. Reset mid-frame flushes the FIFO and drops the frame; done is not pulsed.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, cfg_start=1, cfg_len!=0: latch len, clear counters -> RUN.
  - IDLE, cfg_start=1, cfg_len==0: -> DONE. No beats are emitted.
  - RUN: when the input push count reaches len -> DRAIN.
  - DRAIN: on the ss handshake carrying tlast -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- cfg_start outside IDLE: ignored, no effect.
- in_ready = (state==RUN) && !fifo_full && (push_cnt < len). It is never high in IDLE, DRAIN or DONE.
- Push: in_valid && in_ready. Each FIFO entry stores {last, data}, with last = (push_cnt == len-1).
- Pop: ss_tvalid && ss_tready. ss_tvalid = !fifo_empty.
- ss_tdata and ss_tlast come from the FIFO head and are held stable while ss_tvalid && !ss_tready (AXI-Stream rule).
- Latency: a sample pushed in cycle N is visible on ss_* no earlier than cycle N+1. The FIFO has registered occupancy with no fall-through.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle. There is no ready pass-through, to avoid a combinational path from ss_tready to in_ready.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- Pointers wrap modulo pFIFO_DEPTH. Occupancy is tracked with a counter of width log2(depth)+1.
- sent_cnt increments on each pop, saturates at len, and is cleared on an accepted start. It holds its value in IDLE after done.
- busy = (state != IDLE).
- Arithmetic: all counts are unsigned pLEN_WIDTH. Data passes through untouched (no sign handling).

Optional Feature:
- Macro: FRAMER_STALL_CNT_EN.
- Defined: adds output port stall_cnt [31:0], counting cycles with ss_tvalid && !ss_tready while busy.
  - Cleared on an accepted start.
  - Saturates at 0xFFFF_FFFF.
  - Held after done.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package framer_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - FIFO depth and pointer-width localparams, derived with $clog2;
  - the entry struct {last, data}.
- Sub-module framer_fifo: synchronous FIFO with push/pop/full/empty and registered storage. The FSM and counters live in axis_sample_framer.

Test Plan:
- Basic frame, always ready: cfg_len=600, the samples_triangular_wave values, ss_tready=1 -> 600 beats in order, ss_tlast only on beat 599, done pulses one cycle after that handshake, sent_cnt=600.
- Backpressure: cfg_len=8, ss_tready toggling 1,0,0,1 repeating -> data/tlast stable during stalls, in_ready drops once 4 entries are held, all 8 beats delivered in order. With FRAMER_STALL_CNT_EN, stall_cnt equals the counted stall cycles.
- Zero and one length:
  - cfg_len=0 -> busy high for 1 cycle, done pulses, no ss_tvalid.
  - cfg_len=1, data 0x7FFF_FFFF -> single beat with tlast=1.
- Extra input: cfg_len=3, source offers 5 samples -> only 3 accepted, in_ready stays 0 afterwards, the 4th sample is not consumed.
- Start while busy: cfg_start with cfg_len=5 mid-frame of a cfg_len=10 run -> ignored, exactly 10 beats, single done.
- Reset mid-frame: axis_rst=1 after 3 of 10 beats -> next cycle ss_tvalid=0, busy=0, done=0, FIFO empty. A fresh start with cfg_len=2 then yields exactly 2 beats.
